// File: rtl/retire_amt.sv
// Retire stage: commits ROB retirements into the architectural map table and frees superseded tags.
// Optional RETIRE_PERF_EN adds perf_cycles / perf_retired counters.
module retire_amt #(
  parameter int WAYS         = 2,
  parameter int N_ARCH       = 32,
  parameter int PR_BITS      = 6,
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WAYS-1:0]           ret_valid,
  input  logic [WAYS*PR_BITS-1:0]   ret_t_idx,
  input  logic [WAYS*PR_BITS-1:0]   ret_told_idx,
  input  logic [WAYS*5-1:0]         ret_ar_idx,
  input  logic [WAYS-1:0]           ret_halt,
  input  logic [WAYS-1:0]           ret_pse,
  input  logic [WAYS*XLEN-1:0]      ret_target_pc,
  output logic [WAYS-1:0]           free_valid,
  output logic [WAYS*PR_BITS-1:0]   free_idx,
  output logic                      flush,
  output logic [XLEN-1:0]           flush_pc,
  output logic [N_ARCH*PR_BITS-1:0] amt_out,
  output logic                      retire_stall,
  output logic                      halted
`ifdef RETIRE_PERF_EN
  ,
  output logic [63:0]               perf_cycles,
  output logic [63:0]               perf_retired
`endif
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int AW = $clog2(WAYS + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_HALTED
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [PR_BITS-1:0]   amt      [N_ARCH];
  logic [PR_BITS-1:0]   amt_nxt  [N_ARCH];
  logic [WAYS-1:0]      free_v_nxt;
  logic [WAYS*PR_BITS-1:0] free_i_nxt;
  logic                 go_flush;
  logic [XLEN-1:0]      pse_pc;
  logic                 blocked;
  logic [4:0]           ar;
  logic [AW-1:0]        n_acc;

  // Ways are scanned in order; the first halt/pse way closes the group so later ways
  // neither commit nor free. Later ways overwrite earlier ones in amt_nxt.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    amt_nxt    = amt;
    free_v_nxt = '0;
    free_i_nxt = '0;
    go_flush   = 1'b0;
    pse_pc     = '0;
    blocked    = 1'b0;
    ar         = '0;
    n_acc      = '0;
    case (state)
      ST_RUN: begin
        for (int unsigned i = 0; i < WAYS; i++) begin
          if (ret_valid[i] && !blocked) begin
            n_acc = n_acc + AW'(1);
            ar    = ret_ar_idx[i*5 +: 5];
            if (ar != 5'd0 && int'(ar) < N_ARCH) begin
              amt_nxt[ar]                    = ret_t_idx[i*PR_BITS +: PR_BITS];
              free_v_nxt[i]                  = 1'b1;
              free_i_nxt[i*PR_BITS +: PR_BITS] = ret_told_idx[i*PR_BITS +: PR_BITS];
            end
            if (ret_halt[i]) begin
              blocked   = 1'b1;
              state_nxt = ST_HALTED;
            end else if (ret_pse[i]) begin
              blocked   = 1'b1;
              go_flush  = 1'b1;
              pse_pc    = ret_target_pc[i*XLEN +: XLEN];
              state_nxt = ST_FLUSH;
              cnt_nxt   = CW'(FLUSH_CYCLES - 1);
            end
          end
        end
      end
      ST_FLUSH: begin
        if (cnt == '0) state_nxt = ST_RUN;
        else           cnt_nxt   = cnt - CW'(1);
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < N_ARCH; r++) amt[r] <= PR_BITS'(r);
    end else begin
      for (int unsigned r = 0; r < N_ARCH; r++) amt[r] <= amt_nxt[r];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      free_valid <= '0;
      free_idx   <= '0;
      flush      <= 1'b0;
      flush_pc   <= '0;
    end else begin
      free_valid <= free_v_nxt;
      free_idx   <= free_i_nxt;
      flush      <= go_flush;
      if (go_flush) flush_pc <= pse_pc;
    end
  end

  always_comb begin
    amt_out = '0;
    for (int unsigned r = 0; r < N_ARCH; r++) amt_out[r*PR_BITS +: PR_BITS] = amt[r];
  end

  assign retire_stall = (state != ST_RUN);
  assign halted       = (state == ST_HALTED);

`ifdef RETIRE_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_cycles  <= '0;
      perf_retired <= '0;
    end else if (state != ST_HALTED) begin
      perf_cycles  <= perf_cycles + 64'd1;
      perf_retired <= perf_retired + 64'(n_acc);
    end
  end
`endif

endmodule

// File: tb/tb_retire_amt.sv
// Directed self-checking bench for retire_amt (checks perf counters when RETIRE_PERF_EN is defined).
module tb_retire_amt;

  logic         clock;
  logic         reset;
  logic [1:0]   ret_valid;
  logic [11:0]  ret_t_idx;
  logic [11:0]  ret_told_idx;
  logic [9:0]   ret_ar_idx;
  logic [1:0]   ret_halt;
  logic [1:0]   ret_pse;
  logic [63:0]  ret_target_pc;
  logic [1:0]   free_valid;
  logic [11:0]  free_idx;
  logic         flush;
  logic [31:0]  flush_pc;
  logic [191:0] amt_out;
  logic         retire_stall;
  logic         halted;
`ifdef RETIRE_PERF_EN
  logic [63:0]  perf_cycles;
  logic [63:0]  perf_retired;
`endif

  int total = 0;
  int bad   = 0;

  retire_amt #(
    .WAYS(2), .N_ARCH(32), .PR_BITS(6), .XLEN(32), .FLUSH_CYCLES(2)
  ) dut (
    .clock(clock), .reset(reset),
    .ret_valid(ret_valid), .ret_t_idx(ret_t_idx), .ret_told_idx(ret_told_idx),
    .ret_ar_idx(ret_ar_idx), .ret_halt(ret_halt), .ret_pse(ret_pse),
    .ret_target_pc(ret_target_pc),
    .free_valid(free_valid), .free_idx(free_idx), .flush(flush), .flush_pc(flush_pc),
    .amt_out(amt_out), .retire_stall(retire_stall), .halted(halted)
`ifdef RETIRE_PERF_EN
    , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] amt_e(input int r);
    return amt_out[r*6 +: 6];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    ret_valid = '0; ret_t_idx = '0; ret_told_idx = '0; ret_ar_idx = '0;
    ret_halt = '0; ret_pse = '0; ret_target_pc = '0;
  endtask

  task automatic set_way(input int w, input logic [4:0] ar, input logic [5:0] t,
                         input logic [5:0] told, input logic h, input logic p,
                         input logic [31:0] pc);
    ret_valid[w]            = 1'b1;
    ret_ar_idx[w*5 +: 5]    = ar;
    ret_t_idx[w*6 +: 6]     = t;
    ret_told_idx[w*6 +: 6]  = told;
    ret_halt[w]             = h;
    ret_pse[w]              = p;
    ret_target_pc[w*32 +: 32] = pc;
  endtask

  initial begin
    clear_in();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    for (int r = 0; r < 32; r++) chk($sformatf("rst_amt%0d", r), amt_e(r), r);
    chk("rst_free_valid", free_valid, 0);
    chk("rst_free_idx", free_idx, 0);
    chk("rst_flush", flush, 0);
    chk("rst_flush_pc", flush_pc, 0);
    chk("rst_stall", retire_stall, 0);
    chk("rst_halted", halted, 0);

    // single retirement
    set_way(0, 5'd5, 6'd40, 6'd5, 1'b0, 1'b0, 32'h0);
    tick(); clear_in();
    chk("w1_free_valid", free_valid, 2'b01);
    chk("w1_free_idx0", free_idx[5:0], 5);
    chk("w1_amt5", amt_e(5), 40);

    // same destination in both ways: higher way wins, both told freed
    set_way(0, 5'd7, 6'd41, 6'd7, 1'b0, 1'b0, 32'h0);
    set_way(1, 5'd7, 6'd42, 6'd41, 1'b0, 1'b0, 32'h0);
    tick(); clear_in();
    chk("dup_amt7", amt_e(7), 42);
    chk("dup_free_valid", free_valid, 2'b11);
    chk("dup_free_idx0", free_idx[5:0], 7);
    chk("dup_free_idx1", free_idx[11:6], 41);

    // ar==0 way: no commit, no free
    set_way(0, 5'd0, 6'd50, 6'd9, 1'b0, 1'b0, 32'h0);
    set_way(1, 5'd2, 6'd51, 6'd2, 1'b0, 1'b0, 32'h0);
    tick(); clear_in();
    chk("z_free_valid", free_valid, 2'b10);
    chk("z_free_idx1", free_idx[11:6], 2);
    chk("z_amt0", amt_e(0), 0);
    chk("z_amt2", amt_e(2), 51);

    // pse on way0 squashes way1
    set_way(0, 5'd4, 6'd43, 6'd4, 1'b0, 1'b1, 32'h100);
    set_way(1, 5'd3, 6'd44, 6'd3, 1'b0, 1'b0, 32'h0);
    tick(); clear_in();
    chk("pse_flush", flush, 1);
    chk("pse_flush_pc", flush_pc, 32'h100);
    chk("pse_stall", retire_stall, 1);
    chk("pse_free_valid", free_valid, 2'b01);
    chk("pse_free_idx0", free_idx[5:0], 4);
    chk("pse_amt4", amt_e(4), 43);
    chk("pse_amt3", amt_e(3), 3);
    set_way(0, 5'd6, 6'd45, 6'd6, 1'b0, 1'b0, 32'h0);
    tick();
    chk("fl2_flush", flush, 0);
    chk("fl2_stall", retire_stall, 1);
    chk("fl2_free_valid", free_valid, 0);
    tick(); clear_in();
    chk("fl3_stall", retire_stall, 0);
    chk("fl3_amt6", amt_e(6), 6);
    chk("fl3_free_valid", free_valid, 0);
    chk("fl3_flush", flush, 0);

    // halt together with pse on way0: halt wins, no flush
    set_way(0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b1, 32'h200);
    set_way(1, 5'd9, 6'd47, 6'd9, 1'b0, 1'b0, 32'h0);
    tick(); clear_in();
    chk("h_halted", halted, 1);
    chk("h_stall", retire_stall, 1);
    chk("h_flush", flush, 0);
    chk("h_free_valid", free_valid, 0);
    chk("h_amt9", amt_e(9), 9);
    set_way(0, 5'd8, 6'd46, 6'd8, 1'b0, 1'b0, 32'h0);
    set_way(1, 5'd10, 6'd48, 6'd10, 1'b0, 1'b0, 32'h0);
    tick(); tick(); clear_in();
    chk("h2_amt8", amt_e(8), 8);
    chk("h2_amt10", amt_e(10), 10);
    chk("h2_halted", halted, 1);
    chk("h2_free_valid", free_valid, 0);

    // asynchronous reset out of HALTED
    #2 reset = 1'b0;
    #1;
    chk("ar_halted", halted, 0);
    chk("ar_stall", retire_stall, 0);
    chk("ar_amt4", amt_e(4), 4);
    chk("ar_amt7", amt_e(7), 7);
    tick();
    reset = 1'b1;

    // reset during FLUSH drops the pulse
    set_way(0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1, 32'h300);
    tick(); clear_in();
    chk("mf_flush", flush, 1);
    chk("mf_flush_pc", flush_pc, 32'h300);
    reset = 1'b0;
    #1;
    chk("mf_rst_flush", flush, 0);
    chk("mf_rst_flush_pc", flush_pc, 0);
    chk("mf_rst_stall", retire_stall, 0);
    tick();
    reset = 1'b1;

    // three retirements over four cycles, then halt
    set_way(0, 5'd1, 6'd50, 6'd1, 1'b0, 1'b0, 32'h0);
    tick(); clear_in();
    chk("p1_flush", flush, 0);
    chk("p1_stall", retire_stall, 0);
    chk("p1_free_valid", free_valid, 2'b01);
    tick();
    set_way(0, 5'd2, 6'd51, 6'd2, 1'b0, 1'b0, 32'h0);
    tick(); clear_in();
    set_way(1, 5'd3, 6'd52, 6'd3, 1'b0, 1'b0, 32'h0);
    tick(); clear_in();
    chk("p4_free_valid", free_valid, 2'b10);
    chk("p4_free_idx1", free_idx[11:6], 3);
    set_way(0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0, 32'h0);
    tick(); clear_in();
    chk("p5_halted", halted, 1);
    chk("p5_amt1", amt_e(1), 50);
    chk("p5_amt2", amt_e(2), 51);
    chk("p5_amt3", amt_e(3), 52);
`ifdef RETIRE_PERF_EN
    chk("perf_cycles_h", perf_cycles, 5);
    chk("perf_retired_h", perf_retired, 4);
`endif
    set_way(0, 5'd11, 6'd53, 6'd11, 1'b0, 1'b0, 32'h0);
    tick(); tick(); clear_in();
    chk("p7_amt11", amt_e(11), 11);
`ifdef RETIRE_PERF_EN
    chk("perf_cycles_frozen", perf_cycles, 5);
    chk("perf_retired_frozen", perf_retired, 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/retire_amt.md
Name: retire_amt

Overview:
Retire stage directly downstream of the re-order buffer. It consumes up to SUPERSCALAR_WAYS retired ROB entries per cycle and commits each destination mapping into the architectural map table (AMT). It returns each superseded physical register (told) to the free list. On a precise-state event (mispredicted branch) it raises a registered flush with the recovery PC and the full AMT snapshot; on halt it freezes retirement.

Parameters:
WAYS, 2, retire ways per cycle (matches SUPERSCALAR_WAYS)
N_ARCH, 32, architectural registers; index 0 is hard-wired zero
PR_BITS, 6, physical register index width
XLEN, 32, PC width
FLUSH_CYCLES, 2, cycles spent in FLUSH before retirement resumes (>=1)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
ret_valid  in  WAYS  way i carries a retiring ROB entry
ret_t_idx  in  WAYS*PR_BITS  new physical register of way i
ret_told_idx  in  WAYS*PR_BITS  superseded physical register of way i
ret_ar_idx  in  WAYS*5  architectural destination of way i
ret_halt  in  WAYS  way i is a halt
ret_pse  in  WAYS  way i is a precise_state_enable (redirect)
ret_target_pc  in  WAYS*XLEN  redirect target of way i
free_valid  out  WAYS  registered; told of way i freed
free_idx  out  WAYS*PR_BITS  registered freed physical register
flush  out  1  registered one-cycle pulse: squash pipeline
flush_pc  out  XLEN  fetch redirect PC, valid with flush
amt_out  out  N_ARCH*PR_BITS  current AMT, entry r at bits [r*PR_BITS +: PR_BITS]
retire_stall  out  1  high in FLUSH and HALTED; upstream must not present ret_valid
halted  out  1  sticky, set after halt retires

Behaviour:
- Reset (async on reset falling to 0): AMT[r]=r for all r; free_valid=0, free_idx=0, flush=0, flush_pc=0, halted=0, retire_stall=0; state RUN.
- Way processing order is 0..WAYS-1. A way is accepted iff ret_valid[i], state==RUN, and no lower accepted way had pse or halt. Ways after a pse or halt way are ignored, not freed.
- Accepted way with ar_idx!=0: AMT[ar_idx] <= t_idx at the next edge; free_valid[i]=1, free_idx[i]=told_idx the cycle after acceptance.
- Accepted way with ar_idx==0: no AMT write and no free (free_valid[i]=0).
- Same ar_idx in two ways in one cycle: the higher way wins in the AMT; both told values are freed.
- amt_out reflects the registered AMT. A write becomes visible one cycle after acceptance.
- FSM:
  - RUN: accepted pse way -> FLUSH. Next cycle flush=1 and flush_pc=target_pc of that way; the AMT already includes that way's commit. Accepted halt way -> HALTED. The halt way's own mapping commits; halted=1 next cycle.
  - FLUSH: counter loaded with FLUSH_CYCLES-1; retire_stall=1; inputs ignored; flush pulses only in the first FLUSH cycle. At 0 -> RUN.
  - HALTED: terminal until reset; retire_stall=1; inputs ignored.
- pse and halt on the same way: halt takes priority; no flush.
- Reset mid-FLUSH or mid-HALTED: immediate return to the reset state above; no pending free or flush survives.

Optional Feature:
RETIRE_PERF_EN:
- Defined: adds outputs perf_cycles (64b, increments every cycle after reset until halted) and perf_retired (64b, adds the count of accepted ways each cycle, including ar_idx==0 ways). Both are 0 on reset and frozen once halted.
- Undefined: these ports and counters do not exist.

Test Plan:
- Reset release -> amt_out entry r == r for all 32; all outputs 0.
- ret_valid=01, ar=5, t=40, told=5 -> next cycle free_valid=01, free_idx[0]=5; AMT[5]=40.
- ret_valid=11, both ar=7, t=41/42, told=7/41 -> AMT[7]=42; free_idx=7 and 41, free_valid=11.
- ret_valid=11, way0 pse target 0x100, way1 ar=3 -> way1 ignored; flush=1 for one cycle, flush_pc=0x100; retire_stall=1 for 2 cycles; AMT[3] unchanged.
- way0 halt with ar=0 -> halted=1 next cycle, retire_stall=1; later ret_valid ignored; reset low -> halted=0, AMT identity.
- RETIRE_PERF_EN: retire 3 instructions over 4 cycles, then halt -> perf_retired=4 (3 + halt), perf_cycles frozen thereafter.
